parity_packet_ctrl: RTL and testbench
=====================================

// Module: parity_packet_ctrl
// PURPOSE
// Stream-side controller for word parity generation. Accepts a packet of
// DATA_WIDTH words over a valid/ready handshake and forwards each word with
// its generated parity bit through one register stage. Optionally checks a
// received parity bit per word. Accumulates packet-level parity and error
// status, then reports it once per packet.
// PARAMETERS
// DATA_WIDTH   8   word width in bits
// PARITY_TYPE  0   0 = even parity, 1 = odd parity
// MAX_WORDS    16  max words per packet before forced termination (>=1)
// PORTS
// clk          in   1                   rising-edge clock
// rst_n        in   1                   synchronous reset, active-low
// s_valid      in   1                   input word valid
// s_ready      out  1                   input word accepted when valid&ready
// s_data       in   DATA_WIDTH          input word
// s_last       in   1                   final word of packet
// s_par_in     in   1                   received parity bit for s_data
// check_en     in   1                   compare s_par_in (sampled per accepted word)
// m_valid      out  1                   output word valid
// m_ready      in   1                   downstream accept
// m_data       out  DATA_WIDTH          registered copy of s_data
// m_parity     out  1                   generated parity of m_data
// m_last       out  1                   registered s_last, or forced on overflow
// pkt_done     out  1                   1-cycle pulse: packet result valid
// pkt_parity   out  1                   XOR of all word parities in packet
// pkt_err      out  1                   >=1 checked word mismatched
// pkt_ovf      out  1                   packet cut at MAX_WORDS without s_last
// word_count   out  $clog2(MAX_WORDS+1) words in reported packet
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): all outputs 0, state IDLE, accumulators cleared.
// - Word parity p = ^s_data ^ PARITY_TYPE. Even: total ones incl. p is even.
// - Accept = s_valid & s_ready. s_ready = (state!=DONE) & (!m_valid | m_ready).
// - Output stage: on accept, m_data/m_parity/m_last load, m_valid=1 next cycle.
//   m_valid holds with stable data until m_ready. Latency s->m is 1 cycle.
// - Simultaneous m_ready & accept: the stage reloads and m_valid stays 1.
// - FSM: IDLE -> ACTIVE on accept without last. IDLE/ACTIVE -> DONE on an
//   accept with s_last, or on the MAX_WORDS-th accept. DONE -> IDLE after
//   exactly one cycle. s_ready=0 while in DONE (one bubble per packet).
// - Accumulators update on each accept: acc_par ^= p; cnt += 1;
//   acc_err |= check_en & (s_par_in != p).
// - The DONE entry registers the packet result, including the final word:
//   pkt_done=1 for that single cycle, and pkt_parity/pkt_err/pkt_ovf/word_count
//   hold until the next pkt_done. The accumulators clear in the same cycle.
// - Overflow: the MAX_WORDS-th word is accepted without s_last, so m_last is
//   forced to 1 and pkt_ovf=1. If s_last is also 1 on that word, pkt_ovf=0.
// - A 1-word packet (s_last on the first word) goes IDLE->DONE, word_count=1.
// - check_en=0 on a word: that word never sets acc_err.
// - Reset mid-packet: the partial packet is discarded, there is no pkt_done,
//   and m_valid drops to 0.
// - Output backpressure does not affect packet accounting. Results are
//   reported on accept, not on downstream drain.
// TESTING
// T1 even, 1-word s_data=8'hFF,s_last=1 -> m_parity=0, pkt_parity=0,
//    word_count=1, and pkt_done high for 1 cycle.
// T2 even, words 8'hFF,8'h54,8'h01(last) -> m_parity 0,1,1; pkt_parity=0,
//    word_count=3; PARITY_TYPE=1 gives 1,0,0 and pkt_parity=1.
// T3 check_en=1, 8'h54 with s_par_in=0 -> pkt_err=1; next packet has
//    correct s_par_in -> pkt_err=0 (sticky per packet only).
// T4 MAX_WORDS=4, stream 5 words, no last -> m_last on word 4, pkt_ovf=1,
//    word_count=4, and word 5 starts a new packet after a 1-cycle s_ready bubble.
// T5 m_ready=0 for 5 cycles mid-packet -> s_ready=0, m_data stable, no words
//    lost or duplicated, and counts are correct after release.
// T6 rst_n=0 after 2 of 3 words -> outputs 0, no pkt_done; the next packet
//    of 1 word reports word_count=1.

Source files
------------

// File: rtl/parity_packet_ctrl.sv
// Packet parity controller: forwards words with generated parity through one
// register stage and reports per-packet parity/error/overflow status.
module parity_packet_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_TYPE = 0,
  parameter int MAX_WORDS   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_last,
  input  logic                             s_par_in,
  input  logic                             check_en,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_parity,
  output logic                             m_last,
  output logic                             pkt_done,
  output logic                             pkt_parity,
  output logic                             pkt_err,
  output logic                             pkt_ovf,
  output logic [$clog2(MAX_WORDS+1)-1:0]   word_count
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WORDS - 1);
  localparam logic PAR_INIT = (PARITY_TYPE != 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          acc_par;
  logic          acc_err;

  logic word_par;
  logic accept;
  logic at_max;
  logic closing;
  logic word_err;

  always_comb begin
    word_par = (^s_data) ^ PAR_INIT;
    s_ready  = (state != DONE) && (!m_valid || m_ready);
    accept   = s_valid && s_ready;
    at_max   = (cnt == CNT_LAST);
    closing  = s_last || at_max;
    word_err = check_en && (s_par_in != word_par);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, ACTIVE: if (accept) state <= closing ? DONE : ACTIVE;
        DONE:         state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

  // Single output register: reloads whenever a word is accepted, which the
  // s_ready term only allows when the stage is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_parity <= 1'b0;
      m_last   <= 1'b0;
    end else if (accept) begin
      m_valid  <= 1'b1;
      m_data   <= s_data;
      m_parity <= word_par;
      m_last   <= closing;
    end else if (m_ready) begin
      m_valid  <= 1'b0;
    end
  end

  // The closing word is folded straight into the reported result so the
  // accumulators can clear on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      acc_par    <= 1'b0;
      acc_err    <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_parity <= 1'b0;
      pkt_err    <= 1'b0;
      pkt_ovf    <= 1'b0;
      word_count <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (accept) begin
        if (closing) begin
          pkt_done   <= 1'b1;
          pkt_parity <= acc_par ^ word_par;
          pkt_err    <= acc_err | word_err;
          pkt_ovf    <= !s_last;
          word_count <= cnt + CW'(1);
          cnt        <= '0;
          acc_par    <= 1'b0;
          acc_err    <= 1'b0;
        end else begin
          cnt        <= cnt + CW'(1);
          acc_par    <= acc_par ^ word_par;
          acc_err    <= acc_err | word_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_packet_ctrl.sv
// Bench for parity_packet_ctrl: even and odd instances share stimulus; a
// cycle model plus word scoreboard checks every output each cycle.
module tb_parity_packet_ctrl;

  localparam int MAXW = 4;
  localparam int CW   = $clog2(MAXW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, s_valid, s_last, s_par_in, check_en, m_ready;
  logic [7:0]    s_data;
  logic          e_sready, e_mvalid, e_mpar, e_mlast, e_done, e_ppar, e_perr, e_povf;
  logic          o_sready, o_mvalid, o_mpar, o_mlast, o_done, o_ppar, o_perr, o_povf;
  logic [7:0]    e_mdata, o_mdata;
  logic [CW-1:0] e_wc, o_wc;

  parity_packet_ctrl #(.DATA_WIDTH(8), .PARITY_TYPE(0), .MAX_WORDS(MAXW)) u_even (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(e_sready), .s_data(s_data),
    .s_last(s_last), .s_par_in(s_par_in), .check_en(check_en), .m_valid(e_mvalid),
    .m_ready(m_ready), .m_data(e_mdata), .m_parity(e_mpar), .m_last(e_mlast),
    .pkt_done(e_done), .pkt_parity(e_ppar), .pkt_err(e_perr), .pkt_ovf(e_povf),
    .word_count(e_wc));

  parity_packet_ctrl #(.DATA_WIDTH(8), .PARITY_TYPE(1), .MAX_WORDS(MAXW)) u_odd (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(o_sready), .s_data(s_data),
    .s_last(s_last), .s_par_in(s_par_in), .check_en(check_en), .m_valid(o_mvalid),
    .m_ready(m_ready), .m_data(o_mdata), .m_parity(o_mpar), .m_last(o_mlast),
    .pkt_done(o_done), .pkt_parity(o_ppar), .pkt_err(o_perr), .pkt_ovf(o_povf),
    .word_count(o_wc));

  typedef struct {
    logic [7:0] d;
    logic       p0;
    logic       p1;
    logic       last;
  } word_t;

  typedef struct {
    logic [7:0] d;
    logic last, chk, pin, pe, po, cp, ppe, ppo, erre, erro;
    int   wc;
  } vec_t;

  word_t q[$];
  bit    x_mvalid, x_done_st, x_pdone, x_pp0, x_pp1, x_pe0, x_pe1, x_povf;
  int    x_wc;
  bit    a_p0, a_p1, a_e0, a_e1;
  int    a_cnt;
  bit    cur_p0, cur_p1, prev_rst, acc_flag;
  int    n_vec, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    x_mvalid = 0; x_done_st = 0; x_pdone = 0;
    x_pp0 = 0; x_pp1 = 0; x_pe0 = 0; x_pe1 = 0; x_povf = 0; x_wc = 0;
    a_p0 = 0; a_p1 = 0; a_e0 = 0; a_e1 = 0; a_cnt = 0;
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    bit sr, acc, closing, e0, e1;
    word_t w;
    @(negedge clk);
    acc_flag = 0;
    if (!rst_n) begin
      model_reset();
      prev_rst = 1;
    end else begin
      if (prev_rst) begin
        chk("rst_m_data_even", e_mdata, 0);  chk("rst_m_data_odd", o_mdata, 0);
        chk("rst_m_parity_even", e_mpar, 0); chk("rst_m_parity_odd", o_mpar, 0);
        chk("rst_m_last_even", e_mlast, 0);  chk("rst_m_last_odd", o_mlast, 0);
        prev_rst = 0;
      end
      sr = !x_done_st && (!x_mvalid || m_ready);
      chk("s_ready_even", e_sready, sr);  chk("s_ready_odd", o_sready, sr);
      chk("m_valid_even", e_mvalid, x_mvalid); chk("m_valid_odd", o_mvalid, x_mvalid);
      if (x_mvalid && q.size() > 0) begin
        w = q[0];
        chk("m_data_even", e_mdata, w.d);   chk("m_data_odd", o_mdata, w.d);
        chk("m_parity_even", e_mpar, w.p0); chk("m_parity_odd", o_mpar, w.p1);
        chk("m_last_even", e_mlast, w.last); chk("m_last_odd", o_mlast, w.last);
        if (m_ready) void'(q.pop_front());
      end
      chk("pkt_done_even", e_done, x_pdone);  chk("pkt_done_odd", o_done, x_pdone);
      chk("pkt_parity_even", e_ppar, x_pp0);  chk("pkt_parity_odd", o_ppar, x_pp1);
      chk("pkt_err_even", e_perr, x_pe0);     chk("pkt_err_odd", o_perr, x_pe1);
      chk("pkt_ovf_even", e_povf, x_povf);    chk("pkt_ovf_odd", o_povf, x_povf);
      chk("word_count_even", e_wc, x_wc);     chk("word_count_odd", o_wc, x_wc);

      acc = s_valid && sr;
      acc_flag = acc;
      x_pdone = 0;
      closing = s_last || (a_cnt == MAXW - 1);
      if (acc) begin
        w.d = s_data; w.p0 = cur_p0; w.p1 = cur_p1; w.last = closing;
        q.push_back(w);
        e0 = check_en && (s_par_in != cur_p0);
        e1 = check_en && (s_par_in != cur_p1);
        if (closing) begin
          x_pdone = 1;
          x_pp0 = a_p0 ^ cur_p0; x_pp1 = a_p1 ^ cur_p1;
          x_pe0 = a_e0 | e0;     x_pe1 = a_e1 | e1;
          x_povf = !s_last;      x_wc = a_cnt + 1;
          a_p0 = 0; a_p1 = 0; a_e0 = 0; a_e1 = 0; a_cnt = 0;
        end else begin
          a_p0 ^= cur_p0; a_p1 ^= cur_p1;
          a_e0 |= e0;     a_e1 |= e1;
          a_cnt++;
        end
      end
      x_mvalid  = acc ? 1'b1 : (m_ready ? 1'b0 : x_mvalid);
      x_done_st = acc && closing;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic ce, input logic pin,
                      input logic p0, input logic p1, input bit rnd, output int ncyc);
    s_valid = 1; s_data = d; s_last = last; check_en = ce; s_par_in = pin;
    cur_p0 = p0; cur_p1 = p1; ncyc = 0;
    do begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      cycle();
      ncyc++;
    end while (!acc_flag && ncyc < 40);
    if (!acc_flag) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: word %0h got 0 accepts, want 1", d);
    end
    s_valid = 0; s_last = 0; check_en = 0; s_par_in = 0;
  endtask

  function automatic logic par_even(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic send_auto(input logic [7:0] d, input logic last, input bit rnd, output int ncyc);
    logic ce, pin;
    ce  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    pin = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    send(d, last, ce, pin, par_even(d), ~par_even(d), rnd, ncyc);
  endtask

  vec_t tbl[9];
  int   nc;

  initial begin
    n_vec = 0; n_bad = 0; prev_rst = 0; acc_flag = 0; cur_p0 = 0; cur_p1 = 0;
    model_reset();
    rst_n = 0; s_valid = 0; s_data = '0; s_last = 0; s_par_in = 0; check_en = 0; m_ready = 1;

    //          d      last  chk   pin   pe    po    cp    ppe   ppo   erre  erro  wc
    tbl[0] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[1] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2] = '{8'h54, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[3] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[4] = '{8'h54, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[5] = '{8'h54, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[7] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[8] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3};

    cycle(); cycle();
    rst_n = 1;
    cycle();
    chk("rst_pkt_done", e_done, 0);
    chk("rst_word_count", e_wc, 0);

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].d, tbl[i].last, tbl[i].chk, tbl[i].pin, tbl[i].pe, tbl[i].po, 0, nc);
      if (tbl[i].cp) begin
        chk($sformatf("tbl%0d_pkt_done", i), e_done, 1);
        chk($sformatf("tbl%0d_pkt_parity_even", i), e_ppar, tbl[i].ppe);
        chk($sformatf("tbl%0d_pkt_parity_odd", i), o_ppar, tbl[i].ppo);
        chk($sformatf("tbl%0d_pkt_err_even", i), e_perr, tbl[i].erre);
        chk($sformatf("tbl%0d_pkt_err_odd", i), o_perr, tbl[i].erro);
        chk($sformatf("tbl%0d_word_count", i), e_wc, tbl[i].wc);
      end
    end
    cycle(); cycle();

    // overflow at MAX_WORDS, then the fifth word opens a new packet after one bubble
    send_auto(8'h11, 1'b0, 0, nc);
    send_auto(8'h22, 1'b0, 0, nc);
    send_auto(8'h33, 1'b0, 0, nc);
    send_auto(8'h44, 1'b0, 0, nc);
    chk("ovf_m_last_even", e_mlast, 1); chk("ovf_m_last_odd", o_mlast, 1);
    chk("ovf_pkt_ovf", e_povf, 1);      chk("ovf_word_count", e_wc, 4);
    send_auto(8'h55, 1'b0, 0, nc);
    chk("ovf_bubble_cycles", nc, 2);
    send_auto(8'h66, 1'b1, 0, nc);
    chk("after_ovf_word_count", e_wc, 2); chk("after_ovf_pkt_ovf", e_povf, 0);
    cycle();

    // downstream stall mid-packet
    send_auto(8'hA1, 1'b0, 0, nc);
    send_auto(8'hA2, 1'b0, 0, nc);
    m_ready = 0;
    s_valid = 1; s_data = 8'hA3; s_last = 0; cur_p0 = par_even(8'hA3); cur_p1 = ~par_even(8'hA3);
    repeat (5) cycle();
    chk("stall_s_ready", e_sready, 0);
    chk("stall_m_data_held", e_mdata, 8'hA2);
    m_ready = 1;
    send_auto(8'hA3, 1'b0, 0, nc);
    send_auto(8'hA4, 1'b1, 0, nc);
    chk("stall_word_count", e_wc, 4); chk("last_at_max_pkt_ovf", e_povf, 0);
    cycle();

    // reset mid-packet discards the partial packet
    send_auto(8'hB1, 1'b0, 0, nc);
    send_auto(8'hB2, 1'b0, 0, nc);
    rst_n = 0;
    cycle();
    rst_n = 1;
    cycle();
    chk("midrst_m_valid", e_mvalid, 0); chk("midrst_pkt_done", e_done, 0);
    chk("midrst_word_count", e_wc, 0);
    send_auto(8'hC3, 1'b1, 0, nc);
    chk("post_rst_word_count", e_wc, 1); chk("post_rst_pkt_done", e_done, 1);
    cycle();

    // random packets with random downstream backpressure
    for (int p = 0; p < 20; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int w = 0; w < len; w++)
        send_auto(8'($urandom), (w == len - 1), 1, nc);
    end
    m_ready = 1;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
